// File: rtl/task_launch_ctrl_pkg.sv
// Shared types and defaults for the multi-channel job launcher.
// Imported by the interface, the arbiter and the top.
package task_launch_ctrl_pkg;

  localparam int N_CH_DEF      = 4;
  localparam int ARG_W_DEF     = 32;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY
  } state_t;

  typedef struct packed {
    logic busy;
    logic err_any;
    logic cmpl_timeout;
  } flags_t;

  typedef struct packed {
    logic err_clear;
  } ctrl_t;

endpackage

// File: rtl/task_launch_ctrl_if.sv
// Request, launch and completion bundle of the job launcher.
// master is the environment side, slave is the controller.
interface task_launch_ctrl_if
  import task_launch_ctrl_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int ARG_W = ARG_W_DEF
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]       start_valid;
  logic [N_CH-1:0]       start_ready;
  logic [N_CH*ARG_W-1:0] start_arg;

  logic             launch_valid;
  logic             launch_ready;
  logic [ARG_W-1:0] launch_arg;
  logic [CH_W-1:0]  launch_ch;

  logic dp_done;
  logic dp_abort;

  logic            cmpl_valid;
  logic [CH_W-1:0] cmpl_ch;
  logic            cmpl_timeout;

  modport master (
    output start_valid, start_arg,
    output launch_ready, dp_done,
    input  start_ready,
    input  launch_valid, launch_arg, launch_ch,
    input  dp_abort,
    input  cmpl_valid, cmpl_ch, cmpl_timeout
  );

  modport slave (
    input  start_valid, start_arg,
    input  launch_ready, dp_done,
    output start_ready,
    output launch_valid, launch_arg, launch_ch,
    output dp_abort,
    output cmpl_valid, cmpl_ch, cmpl_timeout
  );

endinterface

// File: rtl/task_launch_ctrl_rr_arbiter.sv
// Combinational round-robin grant starting at ptr, plus the
// next pointer value (grant + 1 mod N) when advance is high.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic [W-1:0] ptr_nxt
);

  always_comb begin
    logic         found;
    logic [W-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      sel = W'((int'(ptr) + i) % N);
      if (!found && req[sel]) begin
        found      = 1'b1;
        gnt[sel]   = 1'b1;
        gnt_idx    = sel;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (advance) begin
      if (int'(gnt_idx) == N - 1)
        ptr_nxt = '0;
      else
        ptr_nxt = gnt_idx + W'(1);
    end
  end

endmodule

// File: rtl/task_launch_ctrl.sv
// Round-robin job launcher: start -> launch -> wait done/timeout,
// then a one-cycle completion report per channel.
module task_launch_ctrl
  import task_launch_ctrl_pkg::*;
#(
  parameter  int N_CH      = N_CH_DEF,
  parameter  int ARG_W     = ARG_W_DEF,
  parameter  int TIMEOUT_W = TIMEOUT_W_DEF,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 err_clear,
  output logic                 busy,
  output logic [N_CH-1:0]      err_sticky,
  task_launch_ctrl_if.slave    bus
);

  state_t state_q, state_d;

  logic [CH_W-1:0]      ptr_q, ptr_nxt, gnt_idx, ch_q;
  logic [N_CH-1:0]      req, gnt, err_q, err_set;
  logic [ARG_W-1:0]     arg_q;
  logic [TIMEOUT_W-1:0] tmo_q, timer_q;
  logic                 start_hs, launch_hs;
  logic                 done_ev, tmo_ev, fin;
  logic                 cmpl_valid_q, cmpl_timeout_q;
  logic                 dp_abort_q;
  logic [CH_W-1:0]      cmpl_ch_q;
  ctrl_t                ctrl;

  assign ctrl.err_clear = err_clear;

  // Grants are only offered in IDLE and never while reset is held.
  assign req = (state_q == IDLE && !rst) ? bus.start_valid : '0;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .advance (start_hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr_nxt (ptr_nxt)
  );

  assign start_hs  = |gnt;
  assign launch_hs = (state_q == LAUNCH) && bus.launch_ready;
  assign done_ev   = (state_q == BUSY) && bus.dp_done;
  assign tmo_ev    = (state_q == BUSY) && !bus.dp_done
                  && (tmo_q != '0)
                  && (timer_q == tmo_q - TIMEOUT_W'(1));
  assign fin       = done_ev | tmo_ev;
  assign err_set   = tmo_ev ? (N_CH'(1) << ch_q) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_hs) state_d = LAUNCH;
      LAUNCH:  if (bus.launch_ready) state_d = BUSY;
      BUSY:    if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      arg_q          <= '0;
      ch_q           <= '0;
      tmo_q          <= '0;
      timer_q        <= '0;
      cmpl_valid_q   <= 1'b0;
      cmpl_timeout_q <= 1'b0;
      cmpl_ch_q      <= '0;
      dp_abort_q     <= 1'b0;
      err_q          <= '0;
    end else begin
      ptr_q <= ptr_nxt;
      if (start_hs) begin
        arg_q <= bus.start_arg[int'(gnt_idx)*ARG_W +: ARG_W];
        ch_q  <= gnt_idx;
      end
      // Zero timeout leaves the timer parked at all-ones.
      if (launch_hs) begin
        tmo_q   <= cfg_timeout;
        timer_q <= '0;
      end else if (state_q == BUSY && timer_q != '1) begin
        timer_q <= timer_q + TIMEOUT_W'(1);
      end
      cmpl_valid_q   <= fin;
      cmpl_timeout_q <= tmo_ev;
      cmpl_ch_q      <= fin ? ch_q : '0;
      dp_abort_q     <= tmo_ev;
      err_q <= (err_q & ~{N_CH{ctrl.err_clear}}) | err_set;
    end
  end

  assign bus.start_ready  = gnt;
  assign bus.launch_valid = (state_q == LAUNCH);
  assign bus.launch_arg   = arg_q;
  assign bus.launch_ch    = ch_q;
  assign bus.dp_abort     = dp_abort_q;
  assign bus.cmpl_valid   = cmpl_valid_q;
  assign bus.cmpl_ch      = cmpl_ch_q;
  assign bus.cmpl_timeout = cmpl_timeout_q;
  assign busy             = (state_q != IDLE);
  assign err_sticky       = err_q;

endmodule

// File: tb/tb_task_launch_ctrl.sv
// Directed bench for task_launch_ctrl with a launch/completion
// scoreboard checked on every cycle.
module tb_task_launch_ctrl;
  import task_launch_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] cfg_timeout;
  logic          err_clear;
  logic          busy;
  logic [N-1:0]  err_sticky;

  task_launch_ctrl_if #(.N_CH(N), .ARG_W(AW)) bus ();

  task_launch_ctrl #(
    .N_CH(N), .ARG_W(AW), .TIMEOUT_W(TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_timeout (cfg_timeout),
    .err_clear   (err_clear),
    .busy        (busy),
    .err_sticky  (err_sticky),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] arg;
    logic        tmo;
  } exp_t;

  exp_t        launch_q[$];
  exp_t        cmpl_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          abort_cnt = 0;
  logic        start_hs, launch_hs;
  logic [31:0] args [N];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] a,
                      input logic tmo);
    launch_q.push_back('{ch, a, 1'b0});
    cmpl_q.push_back('{ch, 32'h0, tmo});
  endtask

  task automatic set_arg(input int ch, input logic [31:0] a);
    bus.start_arg[ch*AW +: AW] = a;
  endtask

  // Samples the settled cycle, scores it, then advances one clock.
  task automatic step();
    exp_t e;
    #1;
    start_hs  = |(bus.start_valid & bus.start_ready);
    launch_hs = bus.launch_valid && bus.launch_ready;
    if (bus.start_valid != '0)
      chk("start_onehot", $onehot0(bus.start_ready), 1);
    if (launch_hs) begin
      if (launch_q.size() == 0) begin
        chk("launch_unexp", launch_hs, 0);
      end else begin
        e = launch_q.pop_front();
        chk("launch_ch", bus.launch_ch, e.ch);
        chk("launch_arg", bus.launch_arg, e.arg);
      end
    end
    if (bus.cmpl_valid) begin
      if (cmpl_q.size() == 0) begin
        chk("cmpl_unexp", bus.cmpl_valid, 0);
      end else begin
        e = cmpl_q.pop_front();
        chk("cmpl_ch", bus.cmpl_ch, e.ch);
        chk("cmpl_tmo", bus.cmpl_timeout, e.tmo);
        chk("abort_qual", bus.dp_abort, e.tmo);
      end
    end else begin
      chk("abort_no_cmpl", bus.dp_abort, 0);
    end
    if (bus.dp_abort) abort_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(input string tag);
    for (int n = 0; n < 50; n++) begin
      step();
      if (start_hs) break;
    end
    chk(tag, start_hs, 1);
  endtask

  task automatic wait_launch(input string tag);
    for (int n = 0; n < 50; n++) begin
      step();
      if (launch_hs) break;
    end
    chk(tag, launch_hs, 1);
  endtask

  task automatic wait_cmpl(output int k);
    k = 0;
    while (!bus.cmpl_valid && k < 100) begin
      step();
      k++;
    end
  endtask

  initial begin
    int k;
    int n_hs;
    int base;

    rst              = 1'b1;
    cfg_timeout      = '0;
    err_clear        = 1'b0;
    bus.start_valid  = 4'hF;
    bus.start_arg    = '0;
    bus.launch_ready = 1'b1;
    bus.dp_done      = 1'b0;
    for (int i = 0; i < N; i++) begin
      args[i] = 32'hA0A0_0000 | 32'(i);
      set_arg(i, args[i]);
    end

    // Reset state, with requests pending
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", bus.start_ready, 0);
    chk("rst_launch_valid", bus.launch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmpl_valid", bus.cmpl_valid, 0);
    chk("rst_dp_abort", bus.dp_abort, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_launch_ch", bus.launch_ch, 0);
    bus.start_valid = '0;
    rst = 1'b0;
    step();

    // Fairness: all channels requesting, immediate done
    for (int j = 0; j < 6; j++) push(j % N, args[j % N], 1'b0);
    bus.dp_done     = 1'b1;
    bus.start_valid = 4'hF;
    n_hs = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (start_hs) n_hs++;
      if (n_hs == 6) break;
    end
    bus.start_valid = '0;
    chk("fair_hs", n_hs, 6);
    for (int n = 0; n < 50; n++) begin
      if (cmpl_q.size() == 0) break;
      step();
    end
    chk("fair_drain", cmpl_q.size(), 0);
    bus.dp_done = 1'b0;
    step();

    // Single request on ch2, done 5 cycles after BUSY entry
    cfg_timeout = 16'd100;
    set_arg(2, 32'hDEAD_BEEF);
    push(2, 32'hDEAD_BEEF, 1'b0);
    bus.start_valid = 4'b0100;
    wait_start("t1_start");
    bus.start_valid = '0;
    wait_launch("t1_launch");
    repeat (5) step();
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    chk("t1_cmpl_valid", bus.cmpl_valid, 1);
    chk("t1_cmpl_ch", bus.cmpl_ch, 2);
    chk("t1_cmpl_tmo", bus.cmpl_timeout, 0);
    chk("t1_busy", busy, 0);
    step();
    chk("t1_cmpl_pulse", bus.cmpl_valid, 0);

    // Timeout of 10 on ch0, then err_clear
    cfg_timeout = 16'd10;
    push(0, args[0], 1'b1);
    bus.start_valid = 4'b0001;
    wait_start("to_start");
    bus.start_valid = '0;
    wait_launch("to_launch");
    wait_cmpl(k);
    chk("to_latency", k, 10);
    chk("to_abort", bus.dp_abort, 1);
    chk("to_err", err_sticky, 4'b0001);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("to_err_clear", err_sticky, 0);

    // dp_done on the last timer cycle: done wins
    push(3, args[3], 1'b0);
    bus.start_valid = 4'b1000;
    wait_start("r1_start");
    bus.start_valid = '0;
    wait_launch("r1_launch");
    repeat (9) step();
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    chk("r1_cmpl", bus.cmpl_valid, 1);
    chk("r1_tmo", bus.cmpl_timeout, 0);
    chk("r1_abort", bus.dp_abort, 0);
    chk("r1_err", err_sticky, 0);
    step();

    // err_clear coinciding with a timeout on ch1
    cfg_timeout = 16'd4;
    push(1, args[1], 1'b1);
    bus.start_valid = 4'b0010;
    wait_start("r2_start");
    bus.start_valid = '0;
    wait_launch("r2_launch");
    repeat (3) step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("r2_cmpl_tmo", bus.cmpl_timeout, 1);
    chk("r2_err", err_sticky, 4'b0010);
    step();

    // Backpressure, then cfg_timeout change during BUSY
    cfg_timeout = 16'd6;
    bus.launch_ready = 1'b0;
    set_arg(2, 32'h1234_5678);
    push(2, 32'h1234_5678, 1'b1);
    bus.start_valid = 4'b0100;
    wait_start("bp_start");
    bus.start_valid = '0;
    for (int n = 0; n < 7; n++) begin
      chk("bp_valid", bus.launch_valid, 1);
      chk("bp_arg", bus.launch_arg, 32'h1234_5678);
      chk("bp_ch", bus.launch_ch, 2);
      step();
    end
    bus.launch_ready = 1'b1;
    wait_launch("bp_launch");
    cfg_timeout = 16'd3;
    wait_cmpl(k);
    chk("bp_latched_tmo", k, 6);
    chk("bp_err", err_sticky, 4'b0110);
    step();

    // Reset mid-BUSY on ch1
    cfg_timeout = 16'd0;
    launch_q.push_back('{1, args[1], 1'b0});
    bus.start_valid = 4'b0010;
    wait_start("rs_start");
    bus.start_valid = '0;
    wait_launch("rs_launch");
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_launch_valid", bus.launch_valid, 0);
    chk("rs_cmpl", bus.cmpl_valid, 0);
    chk("rs_abort", bus.dp_abort, 0);
    chk("rs_err", err_sticky, 0);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // After reset, all requesting: ch0 first; timeout disabled
    push(0, args[0], 1'b0);
    bus.start_valid = 4'hF;
    wait_start("dis_start");
    bus.start_valid = '0;
    wait_launch("dis_launch");
    base = abort_cnt;
    repeat (70000) step();
    chk("dis_no_abort", abort_cnt, base);
    chk("dis_busy", busy, 1);
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    chk("dis_cmpl", bus.cmpl_valid, 1);
    chk("dis_tmo", bus.cmpl_timeout, 0);
    step();
    chk("sb_launch_empty", launch_q.size(), 0);
    chk("sb_cmpl_empty", cmpl_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
